// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: decode stage with opcode decode, write-through register file,
// RAW hazard detection (drives stall to IF) and the ID/EXE pipeline register.
// Optional macro FORWARDING_EN: stall only on load-use, and export fwd_src1/fwd_src2
// for the EXE forwarding unit.
module id_stage_pipelined #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned EXE_CMD_W  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           instruction,
    input  logic [31:0]           pc_in,
    input  logic                  valid_in,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]     wb_value,
    input  logic                  exe_wb_en,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_mem_read,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    output logic                  stall,
    output logic [EXE_CMD_W-1:0]  exe_cmd,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_en_out,
    output logic [1:0]            br_type,
    output logic [DATA_W-1:0]     val1,
    output logic [DATA_W-1:0]     val2,
    output logic [DATA_W-1:0]     src2_val,
    output logic [REG_ADDR_W-1:0] dest,
    output logic [31:0]           pc_out,
`ifdef FORWARDING_EN
    output logic [REG_ADDR_W-1:0] fwd_src1,
    output logic [REG_ADDR_W-1:0] fwd_src2,
`endif
    output logic                  valid_out
);

    localparam int unsigned NumRegs = 1 << REG_ADDR_W;

    logic [DATA_W-1:0] rf_q [NumRegs];

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0]     imm_ext;

    assign opcode  = instruction[31:26];
    assign rs      = instruction[21 +: REG_ADDR_W];
    assign rt      = instruction[16 +: REG_ADDR_W];
    assign rd      = instruction[11 +: REG_ADDR_W];
    assign imm_ext = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};

    logic [EXE_CMD_W-1:0] dec_cmd;
    logic                 dec_mem_read, dec_mem_write, dec_wb;
    logic [1:0]           dec_br;
    logic                 is_rtype, use_rs, use_rt;

    // Opcode decode; undefined opcodes fall through to NOP (no sources, no control).
    always_comb begin
        dec_cmd       = '0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_wb        = 1'b0;
        dec_br        = 2'b00;
        is_rtype      = 1'b0;
        use_rs        = 1'b1;
        use_rt        = 1'b0;
        case (opcode)
            6'd1:    begin dec_cmd = EXE_CMD_W'(4'b0000); is_rtype = 1'b1; end
            6'd3:    begin dec_cmd = EXE_CMD_W'(4'b0010); is_rtype = 1'b1; end
            6'd5:    begin dec_cmd = EXE_CMD_W'(4'b0100); is_rtype = 1'b1; end
            6'd6:    begin dec_cmd = EXE_CMD_W'(4'b0101); is_rtype = 1'b1; end
            6'd7:    begin dec_cmd = EXE_CMD_W'(4'b0110); is_rtype = 1'b1; end
            6'd8:    begin dec_cmd = EXE_CMD_W'(4'b0111); is_rtype = 1'b1; end
            6'd9,
            6'd10:   begin dec_cmd = EXE_CMD_W'(4'b1000); is_rtype = 1'b1; end
            6'd11:   begin dec_cmd = EXE_CMD_W'(4'b1001); is_rtype = 1'b1; end
            6'd12:   begin dec_cmd = EXE_CMD_W'(4'b1010); is_rtype = 1'b1; end
            6'd32:   begin dec_cmd = EXE_CMD_W'(4'b0000); dec_wb = 1'b1; end
            6'd33:   begin dec_cmd = EXE_CMD_W'(4'b0010); dec_wb = 1'b1; end
            6'd36:   begin dec_mem_read = 1'b1; dec_wb = 1'b1; end
            6'd37:   begin dec_mem_write = 1'b1; use_rt = 1'b1; end
            6'd40:   dec_br = 2'b01;
            6'd41:   begin dec_br = 2'b10; use_rt = 1'b1; end
            6'd42:   begin dec_br = 2'b11; use_rs = 1'b0; end
            default: use_rs = 1'b0;
        endcase
        if (is_rtype) begin
            dec_wb = 1'b1;
            use_rt = 1'b1;
        end
    end

    logic [DATA_W-1:0] rs_val, rt_val;

    // Combinational reads with write-through of the value being written back this cycle.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != '0) rs_val = (wb_en && wb_dest == rs) ? wb_value : rf_q[rs];
        if (rt != '0) rt_val = (wb_en && wb_dest == rt) ? wb_value : rf_q[rt];
    end

    // Register file: cleared in reset, entry 0 never written.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(NumRegs); i++) rf_q[i] <= '0;
        end else if (wb_en && wb_dest != '0) begin
            rf_q[wb_dest] <= wb_value;
        end
    end

    logic rs_live, rt_live, hazard;
    assign rs_live = use_rs && (rs != '0);
    assign rt_live = use_rt && (rt != '0);

`ifdef FORWARDING_EN
    // Only a load in EXE cannot be forwarded in time.
    assign hazard = exe_mem_read && exe_wb_en &&
                    ((rs_live && exe_dest == rs) || (rt_live && exe_dest == rt));
    logic unused_mem;
    assign unused_mem = ^{mem_wb_en, mem_dest};
`else
    logic unused_ld;
    assign unused_ld = exe_mem_read;
    assign hazard = (exe_wb_en && ((rs_live && exe_dest == rs) || (rt_live && exe_dest == rt))) ||
                    (mem_wb_en && ((rs_live && mem_dest == rs) || (rt_live && mem_dest == rt)));
`endif

    assign stall = reset && valid_in && !flush && hazard;

    logic [EXE_CMD_W-1:0]  exe_cmd_q;
    logic                  mem_read_q, mem_write_q, wb_en_q, valid_q;
    logic [1:0]            br_type_q;
    logic [DATA_W-1:0]     val1_q, val2_q, src2_val_q;
    logic [REG_ADDR_W-1:0] dest_q, fwd1_q, fwd2_q;
    logic [31:0]           pc_q;

    // ID/EXE register: flush or stall loads a bubble; invalid slots carry no control.
    always_ff @(posedge clock) begin
        if (!reset || flush || stall) begin
            exe_cmd_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            wb_en_q     <= 1'b0;
            br_type_q   <= 2'b00;
            val1_q      <= '0;
            val2_q      <= '0;
            src2_val_q  <= '0;
            dest_q      <= '0;
            fwd1_q      <= '0;
            fwd2_q      <= '0;
            pc_q        <= '0;
            valid_q     <= 1'b0;
        end else begin
            exe_cmd_q   <= valid_in ? dec_cmd : '0;
            mem_read_q  <= valid_in && dec_mem_read;
            mem_write_q <= valid_in && dec_mem_write;
            wb_en_q     <= valid_in && dec_wb;
            br_type_q   <= valid_in ? dec_br : 2'b00;
            val1_q      <= rs_val;
            val2_q      <= is_rtype ? rt_val : imm_ext;
            src2_val_q  <= rt_val;
            dest_q      <= is_rtype ? rd : rt;
            fwd1_q      <= use_rs ? rs : '0;
            fwd2_q      <= use_rt ? rt : '0;
            pc_q        <= pc_in;
            valid_q     <= valid_in;
        end
    end

    assign exe_cmd   = exe_cmd_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign wb_en_out = wb_en_q;
    assign br_type   = br_type_q;
    assign val1      = val1_q;
    assign val2      = val2_q;
    assign src2_val  = src2_val_q;
    assign dest      = dest_q;
    assign pc_out    = pc_q;
    assign valid_out = valid_q;
`ifdef FORWARDING_EN
    assign fwd_src1  = fwd1_q;
    assign fwd_src2  = fwd2_q;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd1_q, fwd2_q};
`endif

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: stimulus pushes expected results from a
// behavioural model, a monitor pops and compares one cycle later.
module tb_id_stage_pipelined;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction, pc_in;
    logic        valid_in, flush, wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;
    logic        exe_wb_en, exe_mem_read, mem_wb_en;
    logic [4:0]  exe_dest, mem_dest;
    logic        stall;
    logic [3:0]  exe_cmd;
    logic        mem_read, mem_write, wb_en_out, valid_out;
    logic [1:0]  br_type;
    logic [31:0] val1, val2, src2_val, pc_out;
    logic [4:0]  dest;
`ifdef FORWARDING_EN
    logic [4:0]  fwd_src1, fwd_src2;
`endif

    always #5 clock = ~clock;

    id_stage_pipelined dut (
        .clock(clock), .reset(reset), .instruction(instruction), .pc_in(pc_in),
        .valid_in(valid_in), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
        .wb_value(wb_value), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
        .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .stall(stall), .exe_cmd(exe_cmd), .mem_read(mem_read), .mem_write(mem_write),
        .wb_en_out(wb_en_out), .br_type(br_type), .val1(val1), .val2(val2),
        .src2_val(src2_val), .dest(dest), .pc_out(pc_out),
`ifdef FORWARDING_EN
        .fwd_src1(fwd_src1), .fwd_src2(fwd_src2),
`endif
        .valid_out(valid_out)
    );

    typedef struct {
        logic        stall;
        logic [3:0]  cmd;
        logic        mr, mw, wb, valid;
        logic [1:0]  br;
        logic [31:0] v1, v2, s2, pc;
        logic [4:0]  dest, f1, f2;
        logic        chk_ops, chk_pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] mregs [32];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one result per clock, checked just after the edge that produced it.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            chk("stall", 32'(stall), 32'(e.stall));
            chk("exe_cmd", 32'(exe_cmd), 32'(e.cmd));
            chk("mem_read", 32'(mem_read), 32'(e.mr));
            chk("mem_write", 32'(mem_write), 32'(e.mw));
            chk("wb_en_out", 32'(wb_en_out), 32'(e.wb));
            chk("br_type", 32'(br_type), 32'(e.br));
            chk("valid_out", 32'(valid_out), 32'(e.valid));
            if (e.chk_ops) begin
                chk("val1", val1, e.v1);
                chk("val2", val2, e.v2);
                chk("src2_val", src2_val, e.s2);
                chk("dest", 32'(dest), 32'(e.dest));
`ifdef FORWARDING_EN
                chk("fwd_src1", 32'(fwd_src1), 32'(e.f1));
                chk("fwd_src2", 32'(fwd_src2), 32'(e.f2));
`endif
            end
            if (e.chk_pc) chk("pc_out", pc_out, e.pc);
        end
    end

    function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Apply one cycle of inputs, predict the registered result and the stall.
    task automatic drive(input logic rst, input logic [31:0] instr, input logic [31:0] pc,
                         input logic vin, input logic fl,
                         input logic we, input logic [4:0] wd, input logic [31:0] wv,
                         input logic ewe, input logic [4:0] ed, input logic emr,
                         input logic mwe, input logic [4:0] md);
        int          op;
        logic [4:0]  rs, rt, rd;
        logic        rtype, known, use_rs, use_rt, haz, exe_hit, mem_hit;
        logic [31:0] rsv, rtv, imm;
        exp_t        x;
        @(negedge clock);
        reset = rst; instruction = instr; pc_in = pc; valid_in = vin; flush = fl;
        wb_en = we; wb_dest = wd; wb_value = wv;
        exe_wb_en = ewe; exe_dest = ed; exe_mem_read = emr; mem_wb_en = mwe; mem_dest = md;

        op  = int'(instr[31:26]);
        rs  = instr[25:21];
        rt  = instr[20:16];
        rd  = instr[15:11];
        imm = {{16{instr[15]}}, instr[15:0]};
        rtype  = op inside {1, 3, 5, 6, 7, 8, 9, 10, 11, 12};
        known  = rtype || (op inside {32, 33, 36, 37, 40, 41, 42});
        use_rs = known && op != 42;
        use_rt = rtype || op == 37 || op == 41;
        rsv = (rs == 0) ? 32'd0 : (we && wd == rs) ? wv : mregs[rs];
        rtv = (rt == 0) ? 32'd0 : (we && wd == rt) ? wv : mregs[rt];

        exe_hit = ewe && ((use_rs && rs != 0 && ed == rs) || (use_rt && rt != 0 && ed == rt));
        mem_hit = mwe && ((use_rs && rs != 0 && md == rs) || (use_rt && rt != 0 && md == rt));
`ifdef FORWARDING_EN
        haz = exe_hit && emr;
`else
        haz = exe_hit || mem_hit;
`endif
        x = '{stall: rst && vin && !fl && haz, cmd: 4'd0, mr: 1'b0, mw: 1'b0, wb: 1'b0,
              valid: 1'b0, br: 2'd0, v1: 32'd0, v2: 32'd0, s2: 32'd0, pc: 32'd0,
              dest: 5'd0, f1: 5'd0, f2: 5'd0, chk_ops: 1'b1, chk_pc: 1'b0};
        if (!rst) begin
            x.chk_pc = 1'b1;
        end else if (!(fl || x.stall)) begin
            x.valid = vin;
            if (vin) begin
                case (op)
                    3, 33:   x.cmd = 4'd2;
                    5:       x.cmd = 4'd4;
                    6:       x.cmd = 4'd5;
                    7:       x.cmd = 4'd6;
                    8:       x.cmd = 4'd7;
                    9, 10:   x.cmd = 4'd8;
                    11:      x.cmd = 4'd9;
                    12:      x.cmd = 4'd10;
                    default: x.cmd = 4'd0;
                endcase
                x.mr = (op == 36);
                x.mw = (op == 37);
                x.wb = rtype || op == 32 || op == 33 || op == 36;
                x.br = (op == 40) ? 2'd1 : (op == 41) ? 2'd2 : (op == 42) ? 2'd3 : 2'd0;
            end
            x.v1 = rsv;
            x.v2 = rtype ? rtv : imm;
            x.s2 = rtv;
            x.dest = rtype ? rd : rt;
            x.f1 = use_rs ? rs : 5'd0;
            x.f2 = use_rt ? rt : 5'd0;
            x.pc = pc;
            x.chk_ops = vin;
            x.chk_pc = vin;
        end
        exp_q.push_back(x);

        if (!rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else if (we && wd != 0) begin
            mregs[wd] = wv;
        end
    endtask

    // Shorthand for a valid, unflushed instruction with no write-back.
    task automatic issue(input logic [31:0] instr, input logic ewe, input logic [4:0] ed,
                         input logic emr, input logic mwe, input logic [4:0] md);
        drive(1'b1, instr, $urandom, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, ewe, ed, emr, mwe, md);
    endtask

    int unsigned def_ops [17] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41};

    initial begin
        int          wait_cycles;
        logic [5:0]  op;
        logic [31:0] ins;
        reset = 1'b0; instruction = '0; pc_in = '0; valid_in = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_dest = '0; wb_value = '0; exe_wb_en = 1'b0; exe_dest = '0;
        exe_mem_read = 1'b0; mem_wb_en = 1'b0; mem_dest = '0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'hdead_beef;

        // Reset with a hazard-producing ADD on the inputs: outputs 0, stall 0.
        repeat (2) drive(1'b0, mk_r(6'd1, 5'd2, 5'd3, 5'd5), 32'h100, 1'b1, 1'b0,
                         1'b1, 5'd7, 32'h55, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3);
        // Every register reads zero after reset.
        for (int i = 1; i < 32; i++) issue(mk_r(6'd1, 5'(i), 5'(i), 5'd1), 0, 0, 0, 0, 0);
        // Load r2=5, r3=7 through write-back.
        drive(1'b1, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd5, 0, 0, 0, 0, 0);
        drive(1'b1, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd7, 0, 0, 0, 0, 0);
        // ADDI r4,r2,-3.
        issue(mk_i(6'd32, 5'd2, 5'd4, 16'hFFFD), 0, 0, 0, 0, 0);
        // Write-through: SUB r1,r6,r3 while r6 is written with 0x1234.
        drive(1'b1, mk_r(6'd3, 5'd6, 5'd3, 5'd1), 32'h200, 1'b1, 1'b0,
              1'b1, 5'd6, 32'h1234, 0, 0, 0, 0, 0);
        // RAW on r2 from EXE, then MEM, then cleared; then a load-use in EXE.
        issue(mk_r(6'd1, 5'd2, 5'd3, 5'd5), 1, 5'd2, 0, 0, 0);
        issue(mk_r(6'd1, 5'd2, 5'd3, 5'd5), 0, 0, 0, 1, 5'd2);
        issue(mk_r(6'd1, 5'd2, 5'd3, 5'd5), 0, 0, 0, 0, 0);
        issue(mk_r(6'd1, 5'd2, 5'd3, 5'd5), 1, 5'd3, 1, 0, 0);
        // Flush beats a present hazard.
        drive(1'b1, mk_r(6'd1, 5'd2, 5'd3, 5'd5), 32'h300, 1'b1, 1'b1,
              1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3);
        // ST r3,r2,8; BNE with rt hazard; JMP whose rs field matches exe_dest.
        issue(mk_i(6'd37, 5'd2, 5'd3, 16'd8), 0, 0, 0, 0, 0);
        issue(mk_i(6'd41, 5'd1, 5'd3, 16'd4), 1, 5'd3, 1, 0, 0);
        issue(mk_i(6'd42, 5'd2, 5'd0, 16'd4), 1, 5'd2, 1, 0, 0);
        // Valid_in low: no control leaves the stage.
        drive(1'b1, mk_i(6'd36, 5'd1, 5'd2, 16'd0), 32'h0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic over a small register window to provoke hazards and bypasses.
        for (int n = 0; n < 600; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'(def_ops[$urandom_range(0, 16)]);
            if (op == 6'd41 && $urandom_range(0, 3) == 0) op = 6'd42;
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            drive($urandom_range(0, 99) != 0, ins, $urandom,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clock);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
